// File: rtl/c17_response_checker.sv
// ---------------------------------------------------------------------------
// c17_response_checker
//
// Purpose: consumer of the path-balanced c17 netlist. Every vector applied to
// the netlist while RUNning is recorded, its golden N22/N23 recomputed and
// delayed by LATENCY cycles, then compared against the sampled netlist
// outputs. Counts vectors/mismatches, captures the first failure and reports
// pass/fail once the in-flight vectors have drained.
//
// Parameters:
//   LATENCY  cycles from vector applied until N22/N23 valid (1..15)
//   CNT_W    width of vector / error counters
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start, stop         one-cycle control pulses (start wins when both high)
//   in_valid, in_vec    vector applied to the netlist, {N1,N2,N3,N6,N7}
//   dut_n22, dut_n23    sampled netlist outputs
//   busy, done, pass    status (pass only meaningful while done)
//   vec_count           vectors compared (wraps)
//   err_count           mismatching vectors (saturates)
//   first_err_vec/got/idx  vector, observed {N22,N23} and vec_count of the
//                       first mismatch
//
// Optional feature macro: C17_CHK_HALT_ON_ERR_EN
//   When defined, the first mismatch in RUN/DRAIN ends the run: the next cycle
//   is DONE, in-flight entries are discarded and input is ignored until start.
// ---------------------------------------------------------------------------
module c17_response_checker #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [4:0]       in_vec,
    input  logic             dut_n22,
    input  logic             dut_n23,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [4:0]       first_err_vec,
    output logic [1:0]       first_err_got,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [3:0]       DRAIN_LOAD = 4'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t state, state_nx;
    logic [3:0] drain_cnt;

    // Delay line: valid, golden {N22,N23} and the vector itself (for capture).
    logic [LATENCY-1:0]      vld_pipe;
    logic [LATENCY-1:0][1:0] exp_pipe;
    logic [LATENCY-1:0][4:0] vec_pipe;

    logic       v_in;
    logic [1:0] exp_in;
    logic       tap_v;
    logic [1:0] got;
    logic       mism;
    logic       halt_hit;
    logic       flush;

    logic             cap, cap_nx;
    logic [CNT_W-1:0] vec_nx, err_nx, fidx_nx;
    logic [4:0]       fvec_nx;
    logic [1:0]       fgot_nx;
    logic             busy_d, done_d, pass_d;

    // Golden model: bit4=N1 bit3=N2 bit2=N3 bit1=N6 bit0=N7
    assign exp_in[1] = (in_vec[4] & in_vec[2]) | (in_vec[3] & ~(in_vec[2] & in_vec[1]));
    assign exp_in[0] = ~(in_vec[2] & in_vec[1]) & (in_vec[3] | in_vec[0]);

    // Vectors outside RUN never enter the line.
    assign v_in  = in_valid && (state == S_RUN);
    assign tap_v = vld_pipe[LATENCY-1];
    assign got   = {dut_n22, dut_n23};
    assign mism  = tap_v && (got != exp_pipe[LATENCY-1]);

`ifdef C17_CHK_HALT_ON_ERR_EN
    assign halt_hit = mism && ((state == S_RUN) || (state == S_DRAIN));
`else
    assign halt_hit = 1'b0;
`endif

    assign flush = start | halt_hit;

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN: begin
                if (start)         state_nx = S_RUN;
                else if (halt_hit) state_nx = S_DONE;
                else if (stop)     state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (start)                state_nx = S_RUN;
                else if (halt_hit)        state_nx = S_DONE;
                else if (drain_cnt <= 4'd1) state_nx = S_DONE;
            end
            S_DONE:  if (start) state_nx = S_RUN;
            default: state_nx = S_IDLE;
        endcase
    end

    // ---- FSM: outputs (registered from next-state so they line up with counters) ----
    always_comb begin
        busy_d = (state_nx == S_RUN) || (state_nx == S_DRAIN);
        done_d = (state_nx == S_DONE);
        pass_d = done_d && (err_nx == '0);
    end

    // Loaded with LATENCY whenever outside DRAIN; the last DRAIN cycle is the
    // one where the final in-flight vector reaches the tap.
    always_ff @(posedge clk) begin
        if (rst)                 drain_cnt <= '0;
        else if (state != S_DRAIN) drain_cnt <= DRAIN_LOAD;
        else                     drain_cnt <= drain_cnt - 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            exp_pipe <= '0;
            vec_pipe <= '0;
        end else begin
            vld_pipe[0] <= v_in & ~flush;
            exp_pipe[0] <= exp_in;
            vec_pipe[0] <= in_vec;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1] & ~flush;
                exp_pipe[i] <= exp_pipe[i-1];
                vec_pipe[i] <= vec_pipe[i-1];
            end
        end
    end

    // ---- counters and first-failure capture ----
    always_comb begin
        vec_nx  = vec_count;
        err_nx  = err_count;
        fvec_nx = first_err_vec;
        fgot_nx = first_err_got;
        fidx_nx = first_err_idx;
        cap_nx  = cap;
        if (start) begin
            vec_nx  = '0;
            err_nx  = '0;
            fvec_nx = '0;
            fgot_nx = '0;
            fidx_nx = '0;
            cap_nx  = 1'b0;
        end else if (tap_v) begin
            vec_nx = vec_count + CNT_ONE;
            if (mism) begin
                if (err_count != '1) err_nx = err_count + CNT_ONE;
                if (!cap) begin
                    cap_nx  = 1'b1;
                    fvec_nx = vec_pipe[LATENCY-1];
                    fgot_nx = got;
                    fidx_nx = vec_count;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_count     <= '0;
            err_count     <= '0;
            first_err_vec <= '0;
            first_err_got <= '0;
            first_err_idx <= '0;
            cap           <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            vec_count     <= vec_nx;
            err_count     <= err_nx;
            first_err_vec <= fvec_nx;
            first_err_got <= fgot_nx;
            first_err_idx <= fidx_nx;
            cap           <= cap_nx;
            busy          <= busy_d;
            done          <= done_d;
            pass          <= pass_d;
        end
    end

endmodule

// File: tb/tb_c17_response_checker.sv
// ---------------------------------------------------------------------------
// Bench for c17_response_checker. A behavioural c17 netlist (NAND form) with
// configurable response skew, stuck-at-1 on N23 and per-vector output
// corruption drives the checker; a counting model predicts its results.
// ---------------------------------------------------------------------------
module tb_c17_response_checker;

    localparam int L = 2;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         in_valid = 1'b0;
    logic [4:0]   in_vec = 5'd0;
    logic         dut_n22, dut_n23;
    logic         busy, done, pass;
    logic [W-1:0] vec_count, err_count, first_err_idx;
    logic [4:0]   first_err_vec;
    logic [1:0]   first_err_got;

    int checks = 0;
    int errors = 0;

    // netlist model controls
    int         skew = 2;
    bit         stuck = 1'b0;
    logic [1:0] xmask = 2'b00;
    logic [1:0] sr [0:7];

    // checker model
    bit         m_run = 1'b0;
    int         m_vec, m_err, m_fidx;
    bit         m_cap;
    logic [4:0] m_fvec;
    logic [1:0] m_fgot;

    c17_response_checker #(.LATENCY(L), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .in_valid(in_valid), .in_vec(in_vec),
        .dut_n22(dut_n22), .dut_n23(dut_n23),
        .busy(busy), .done(done), .pass(pass),
        .vec_count(vec_count), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_got(first_err_got),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Gate-level c17: six NAND2 gates.
    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
        {n1, n2, n3, n6, n7} = v;
        n10 = ~(n1 & n3);
        n11 = ~(n3 & n6);
        n16 = ~(n2 & n11);
        n19 = ~(n11 & n7);
        return {~(n10 & n16), ~(n16 & n19)};
    endfunction

    always @(posedge clk) begin
        sr[0] <= c17(in_vec) ^ xmask;
        for (int k = 1; k < 8; k++) sr[k] <= sr[k-1];
    end
    assign dut_n22 = sr[skew-1][1];
    assign dut_n23 = stuck ? 1'b1 : sr[skew-1][0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_run = 1'b1; m_vec = 0; m_err = 0; m_cap = 1'b0;
        m_fvec = '0; m_fgot = '0; m_fidx = 0;
    endtask

    task automatic apply(input logic [4:0] v, input logic [1:0] mask);
        in_valid = 1'b1;
        in_vec   = v;
        xmask    = mask;
        if (m_run) begin
            if (mask != 2'b00) begin
                if (!m_cap) begin
                    m_cap = 1'b1; m_fvec = v; m_fgot = c17(v) ^ mask; m_fidx = m_vec;
                end
                m_err++;
            end
            m_vec++;
        end
        tick();
        in_valid = 1'b0;
        xmask    = 2'b00;
        in_vec   = 5'($urandom);
    endtask

    // stop, then DONE must appear exactly L cycles later
    task automatic finish_run(input string tag);
        in_valid = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_run = 1'b0;
        repeat (L - 1) tick();
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        tick();
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] seq8 [0:7];
        seq8[0] = 5'b10100; seq8[1] = 5'b01111; seq8[2] = 5'b01000; seq8[3] = 5'b00000;
        seq8[4] = 5'b10100; seq8[5] = 5'b01111; seq8[6] = 5'b01000; seq8[7] = 5'b00000;

        // ---- reset state ----
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_vec",  32'(vec_count), 32'd0);
        chk("rst_err",  32'(err_count), 32'd0);

        // ---- exhaustive 32 vectors, correct netlist ----
        do_start();
        chk("run_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 32; i++) apply(5'(i), 2'b00);
        finish_run("all32");
        chk("all32_pass", {31'd0, pass}, 32'd1);
        chk("all32_vec",  32'(vec_count), 32'd32);
        chk("all32_err",  32'(err_count), 32'd0);
        // stop in DONE is ignored, outputs held
        stop = 1'b1; tick(); stop = 1'b0; tick();
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("done_hold_vec", 32'(vec_count), 32'd32);

        // ---- three directed vectors ----
        do_start();
        apply(5'b10100, 2'b00);
        apply(5'b01111, 2'b00);
        apply(5'b01000, 2'b00);
        finish_run("dir3");
        chk("dir3_vec",  32'(vec_count), 32'd3);
        chk("dir3_err",  32'(err_count), 32'd0);
        chk("dir3_pass", {31'd0, pass}, 32'd1);

`ifndef C17_CHK_HALT_ON_ERR_EN
        // ---- N23 stuck-at-1 ----
        do_start();
        stuck = 1'b1;
        apply(5'b01111, 2'b00);
        apply(5'b10100, 2'b00);
        finish_run("stuck");
        stuck = 1'b0;
        chk("stuck_err",  32'(err_count), 32'd2);
        chk("stuck_fvec", 32'(first_err_vec), 32'b01111);
        chk("stuck_fgot", 32'(first_err_got), 32'b01);
        chk("stuck_fidx", 32'(first_err_idx), 32'd0);
        chk("stuck_pass", {31'd0, pass}, 32'd0);

        // ---- response skewed by one cycle ----
        skew = 3;
        do_start();
        for (int i = 0; i < 8; i++) apply(seq8[i], 2'b00);
        finish_run("skew3");
        chk("skew3_err_nz", {31'd0, (err_count != '0)}, 32'd1);
        chk("skew3_pass",   {31'd0, pass}, 32'd0);
        skew = 2;
`endif
        do_start();
        for (int i = 0; i < 8; i++) apply(seq8[i], 2'b00);
        finish_run("skew2");
        chk("skew2_pass", {31'd0, pass}, 32'd1);
        chk("skew2_vec",  32'(vec_count), 32'd8);

        // ---- random vectors with gaps (and corruption in the default build) ----
        for (int i = 0; i < 3; i++) apply(5'($urandom), 2'b11);  // in DONE: ignored
        do_start();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_vec = 5'($urandom);
                tick();
            end else begin
`ifdef C17_CHK_HALT_ON_ERR_EN
                apply(5'($urandom), 2'b00);
`else
                apply(5'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
`endif
            end
        end
        finish_run("rand");
        chk("rand_vec",  32'(vec_count), 32'(m_vec));
        chk("rand_err",  32'(err_count), 32'(m_err));
        chk("rand_pass", {31'd0, pass}, {31'd0, (m_err == 0)});
        chk("rand_fvec", 32'(first_err_vec), 32'(m_fvec));
        chk("rand_fgot", 32'(first_err_got), 32'(m_fgot));
        chk("rand_fidx", 32'(first_err_idx), 32'(m_fidx));

        // ---- reset mid-RUN ----
        do_start();
        for (int i = 0; i < 5; i++) apply(5'($urandom), 2'b00);
        rst = 1'b1;
        tick();
        m_run = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_vec",  32'(vec_count), 32'd0);
        chk("midrst_err",  32'(err_count), 32'd0);
        rst = 1'b0;
        stop = 1'b1; tick(); stop = 1'b0; tick(); tick();
        chk("midrst_stop_busy", {31'd0, busy}, 32'd0);
        chk("midrst_stop_done", {31'd0, done}, 32'd0);

        // ---- start and stop together in RUN: restart, in-flight flushed ----
        do_start();
        apply(5'b10100, 2'b00);
        apply(5'b01111, 2'b00);
        apply(5'b01000, 2'b00);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        m_vec = 0;
        tick(); tick();
        chk("ss_busy", {31'd0, busy}, 32'd1);
        chk("ss_done", {31'd0, done}, 32'd0);
        chk("ss_vec",  32'(vec_count), 32'd0);
        apply(5'b00000, 2'b00);
        apply(5'b11111, 2'b00);
        finish_run("ss");
        chk("ss_vec2", 32'(vec_count), 32'd2);
        chk("ss_pass", {31'd0, pass}, 32'd1);

`ifdef C17_CHK_HALT_ON_ERR_EN
        // ---- halt on first mismatch ----
        do_start();
        apply(5'b01000, 2'b00);
        apply(5'b10100, 2'b01);
        m_run = 1'b0;
        tick();
        chk("halt_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("halt_done", {31'd0, done}, 32'd1);
        chk("halt_err",  32'(err_count), 32'd1);
        chk("halt_pass", {31'd0, pass}, 32'd0);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) apply(5'($urandom), 2'b11);
        tick(); tick(); tick();
        chk("halt_vec_hold", 32'(vec_count), 32'd2);
        chk("halt_err_hold", 32'(err_count), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/c17_response_checker.md
Name: c17_response_checker

Overview:
- Downstream consumer of the path-balanced c17 netlist (N1,N2,N3,N6,N7 -> N22,N23).
- Records every stimulus vector applied to the netlist and recomputes golden N22/N23 from it.
- Delays the golden values by the netlist's balanced depth, then compares them against the sampled netlist outputs.
- Counts vectors and mismatches, captures the first failure and reports pass/fail once drained. Used on the benchmark bench and in on-chip self-test wrappers.

Parameters:
- LATENCY, 2, cycles from vector applied to netlist until N22/N23 are valid; legal range 1..15.
- CNT_W, 16, width of the vector and error counters.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; clears counters and enters RUN.
- stop  input  1  one-cycle pulse; ends stimulus and enters DRAIN.
- in_valid  input  1  in_vec is applied to the netlist this cycle.
- in_vec  input  5  {N1,N2,N3,N6,N7}; bit4=N1 ... bit0=N7.
- dut_n22  input  1  netlist output N22.
- dut_n23  input  1  netlist output N23.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  high in DONE.
- pass  output  1  valid while done; 1 when err_count==0.
- vec_count  output  CNT_W  number of vectors compared.
- err_count  output  CNT_W  number of mismatching vectors; saturates at all-ones.
- first_err_vec  output  5  in_vec of the first mismatch.
- first_err_got  output  2  {dut_n22,dut_n23} observed at the first mismatch.
- first_err_idx  output  CNT_W  value of vec_count at the first mismatch.

Behaviour:
- Golden model:
  - exp22 = (N1&N3) | (N2 & ~(N3&N6)).
  - exp23 = ~(N3&N6) & (N2|N7).
- Delay line: LATENCY-deep shift register of {v, exp22, exp23}. It shifts every cycle in all states. Its input v is in_valid && state==RUN, so vectors presented outside RUN are ignored.
- Compare: at the tap, if v==1:
  - vec_count increments.
  - If {dut_n22,dut_n23} != {exp22,exp23}, err_count increments (saturating).
  - On the first mismatch only, first_err_* are captured.
  - The DUT outputs are sampled in the same cycle the tap entry is valid, so a vector applied at cycle t is checked against DUT outputs at cycle t+LATENCY.
- vec_count wraps modulo 2^CNT_W. err_count saturates at all-ones.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> DRAIN. If start and stop arrive in the same cycle, start wins: counters clear and the state stays RUN.
  - DRAIN: a down-counter is loaded with LATENCY. Compares continue for entries still in flight. When the counter reaches 0 -> DONE, so DONE is entered exactly LATENCY cycles after stop.
  - DONE: outputs are held; start -> RUN.
- start in any state:
  - Clears vec_count, err_count and first_err_*, plus the capture flag.
  - Flushes the delay line valid bits.
  - Enters RUN.
- stop in IDLE or DONE is ignored.
- Reset (rst=1 at a clock edge), including mid-operation:
  - state=IDLE and all delay-line bits=0.
  - busy=0, done=0, pass=0.
  - All counters and first_err_* = 0.
- pass=0 whenever done=0.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- C17_CHK_HALT_ON_ERR_EN
- When defined, the first mismatch moves RUN or DRAIN directly to DONE on the next cycle:
  - err_count=1, pass=0.
  - In-flight entries are discarded.
  - in_valid is ignored until the next start.
- When undefined, checking runs to completion and counts all mismatches.

Test Plan:
- Reset then start; apply all 32 in_vec values 0..31 with a correct DUT model delayed by 2 -> after stop plus 2 cycles: done=1, pass=1, vec_count=32, err_count=0.
- Vector 5'b10100 (expected 1,0), vector 5'b01111 (expected 0,0) and vector 5'b01000 (expected 1,1) with correct responses -> vec_count=3, err_count=0.
- DUT N23 stuck-at-1, vectors 5'b01111 then 5'b10100 -> err_count=2, first_err_vec=5'b01111, first_err_got=2'b01, first_err_idx=0, pass=0.
- DUT response skewed to 3 cycles, LATENCY=2, 8 varied vectors -> err_count>0, pass=0; skew corrected -> pass=1.
- rst asserted mid-RUN after 5 vectors -> next cycle: busy=0, vec_count=0, err_count=0; stop then has no effect.
- start and stop in the same cycle during RUN -> counters clear and the state stays RUN. With C17_CHK_HALT_ON_ERR_EN defined, one mismatch -> done=1 on the next cycle with err_count=1.
